// File: rtl/rtc_scan_ctrl.sv
// ============================================================================
//  Module   : rtc_scan_ctrl
//  Brief    : Six-digit multiplexed 7-segment scan sequencer with blanking,
//             16-level brightness PWM, digit mask and frame-coherent snapshot.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       i_sclk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_segout1,
    input  logic [7:0] i_segout2,
    input  logic [7:0] i_segout3,
    input  logic [7:0] i_segout4,
    input  logic [7:0] i_segout5,
    input  logic [7:0] i_segout6,
    input  logic [5:0] i_digit_en,
    input  logic [3:0] i_bright,
    output logic [7:0] o_segments,
    output logic [7:0] o_digits,
    output logic [2:0] o_digit_idx,
    output logic       o_frame_start
);

    localparam int              c_DW         = $clog2(DWELL_CYCLES);
    localparam logic [c_DW-1:0] c_BLANK_LAST = c_DW'(BLANK_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL_CYCLES - 1);
    localparam logic [2:0]      c_LAST_IDX   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t            r_state_q,  w_state_d;
    logic [2:0]        r_idx_q,    w_idx_d;
    logic [c_DW-1:0]   r_dwell_q,  w_dwell_d;
    logic [3:0]        r_pwm_q,    w_pwm_d;
    logic [5:0][7:0]   r_snap_seg_q,    w_snap_seg_d;
    logic [5:0]        r_snap_en_q,     w_snap_en_d;
    logic [3:0]        r_snap_bright_q, w_snap_bright_d;
    logic [7:0]        r_seg_q,    w_seg_d;
    logic [7:0]        r_dig_q,    w_dig_d;
    logic              r_frame_q,  w_frame_d;
    logic              w_latch;
    logic              w_lit;

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_dwell_d = r_dwell_q + 1'b1;
        w_pwm_d   = r_pwm_q;
        w_frame_d = 1'b0;
        w_latch   = 1'b0;
        if (!i_enable) begin
            w_state_d = ST_IDLE;
            w_idx_d   = 3'd0;
            w_dwell_d = '0;
            w_pwm_d   = 4'd0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_state_d = ST_BLANK;
                    w_idx_d   = 3'd0;
                    w_dwell_d = '0;
                    w_latch   = 1'b1;
                    w_frame_d = 1'b1;
                end
                ST_BLANK: begin
                    if (r_dwell_q == c_BLANK_LAST) begin
                        w_state_d = ST_ON;
                        w_pwm_d   = 4'd0;
                    end
                end
                ST_ON: begin
                    w_pwm_d = r_pwm_q + 4'd1;
                    if (r_dwell_q == c_DWELL_LAST) begin
                        w_state_d = ST_BLANK;
                        w_dwell_d = '0;
                        // A masked digit still walks through here so refresh rate is fixed
                        if (r_idx_q == c_LAST_IDX) begin
                            w_idx_d   = 3'd0;
                            w_latch   = 1'b1;
                            w_frame_d = 1'b1;
                        end else begin
                            w_idx_d = r_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_idx_d   = 3'd0;
                    w_dwell_d = '0;
                    w_pwm_d   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_snap_seg_d    = r_snap_seg_q;
        w_snap_en_d     = r_snap_en_q;
        w_snap_bright_d = r_snap_bright_q;
        if (w_latch) begin
            w_snap_seg_d    = {i_segout6, i_segout5, i_segout4,
                               i_segout3, i_segout2, i_segout1};
            w_snap_en_d     = i_digit_en;
            w_snap_bright_d = i_bright;
        end
    end

    // Outputs are computed from next-state values so they line up with the state entered
    always_comb begin
        w_lit   = (w_state_d == ST_ON) && w_snap_en_d[w_idx_d] &&
                  (w_pwm_d <= w_snap_bright_d);
        w_seg_d = 8'hFF;
        w_dig_d = 8'hFF;
        if (w_lit) begin
            w_seg_d = ~(8'd1 << w_idx_d);
            w_dig_d = w_snap_seg_d[w_idx_d];
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_state_q       <= ST_IDLE;
            r_idx_q         <= 3'd0;
            r_dwell_q       <= '0;
            r_pwm_q         <= 4'd0;
            r_snap_seg_q    <= '0;
            r_snap_en_q     <= 6'd0;
            r_snap_bright_q <= 4'd0;
            r_seg_q         <= 8'hFF;
            r_dig_q         <= 8'hFF;
            r_frame_q       <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_idx_q         <= w_idx_d;
            r_dwell_q       <= w_dwell_d;
            r_pwm_q         <= w_pwm_d;
            r_snap_seg_q    <= w_snap_seg_d;
            r_snap_en_q     <= w_snap_en_d;
            r_snap_bright_q <= w_snap_bright_d;
            r_seg_q         <= w_seg_d;
            r_dig_q         <= w_dig_d;
            r_frame_q       <= w_frame_d;
        end
    end

    assign o_segments    = r_seg_q;
    assign o_digits      = r_dig_q;
    assign o_digit_idx   = r_idx_q;
    assign o_frame_start = r_frame_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_scan_ctrl.sv
// ============================================================================
//  Module   : tb_rtc_scan_ctrl
//  Brief    : Directed, table-driven bench for rtc_scan_ctrl (dwell 8, blank 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtc_scan_ctrl;

    logic       clk = 1'b0;
    logic       i_reset, i_enable;
    logic [7:0] i_segout1, i_segout2, i_segout3, i_segout4, i_segout5, i_segout6;
    logic [5:0] i_digit_en;
    logic [3:0] i_bright;
    logic [7:0] o_segments, o_digits;
    logic [2:0] o_digit_idx;
    logic       o_frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    rtc_scan_ctrl #(.DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .i_sclk       (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_segout1    (i_segout1),
        .i_segout2    (i_segout2),
        .i_segout3    (i_segout3),
        .i_segout4    (i_segout4),
        .i_segout5    (i_segout5),
        .i_segout6    (i_segout6),
        .i_digit_en   (i_digit_en),
        .i_bright     (i_bright),
        .o_segments   (o_segments),
        .o_digits     (o_digits),
        .o_digit_idx  (o_digit_idx),
        .o_frame_start(o_frame_start)
    );

    // Anode invariant: bits 7:6 high and at most one of 5:0 low, every cycle
    always @(negedge clk) begin
        n_checks++;
        if (o_segments[7:6] != 2'b11 || !$onehot0(~o_segments[5:0])) begin
            n_errors++;
            $display("FAIL anode_invariant t=%0t segments=%h required one-hot-low with 7:6=11",
                     $time, o_segments);
        end
    end

    typedef struct {
        int         scen;
        int         t;
        logic [7:0] seg;
        logic [7:0] dig;
        logic [2:0] idx;
        logic       fs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int s, input int t, input logic [7:0] seg,
                       input logic [7:0] dig, input logic [2:0] idx, input logic fs);
        vec_t v;
        v.scen = s; v.t = t; v.seg = seg; v.dig = dig; v.idx = idx; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] seg, input logic [7:0] dig,
                         input logic [2:0] idx, input logic fs);
        n_checks++;
        if (o_segments !== seg || o_digits !== dig || o_digit_idx !== idx ||
            o_frame_start !== fs) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got seg=%h dig=%h idx=%0d fs=%b want seg=%h dig=%h idx=%0d fs=%b",
                     name, cyc, o_segments, o_digits, o_digit_idx, o_frame_start,
                     seg, dig, idx, fs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    // Park in IDLE, apply config, re-enable; cyc 0 is the frame-start cycle
    task automatic start_scan(input logic [5:0] en, input logic [3:0] br);
        i_enable = 1'b0;
        tick();
        i_digit_en = en;
        i_bright   = br;
        i_segout1  = 8'hC0;
        i_enable   = 1'b1;
        tick();
        cyc = 0;
    endtask

    logic [5:0] en_cfg[4]     = '{6'h3F, 6'h3F, 6'h3F, 6'h3B};
    logic [3:0] bright_cfg[4] = '{4'd15, 4'd0, 4'd7, 4'd3};

    initial begin
        i_reset = 1'b1; i_enable = 1'b0;
        i_segout1 = 8'hC0; i_segout2 = 8'hF9; i_segout3 = 8'hA4;
        i_segout4 = 8'hB0; i_segout5 = 8'h99; i_segout6 = 8'h92;
        i_digit_en = 6'h3F; i_bright = 4'd15;

        // scenario 0: full brightness, all digits
        add(0,  0, 8'hFF, 8'hFF, 3'd0, 1'b1);
        add(0,  1, 8'hFF, 8'hFF, 3'd0, 1'b0);
        add(0,  2, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(0,  7, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(0,  8, 8'hFF, 8'hFF, 3'd1, 1'b0);
        add(0, 10, 8'hFD, 8'hF9, 3'd1, 1'b0);
        add(0, 18, 8'hFB, 8'hA4, 3'd2, 1'b0);
        add(0, 26, 8'hF7, 8'hB0, 3'd3, 1'b0);
        add(0, 34, 8'hEF, 8'h99, 3'd4, 1'b0);
        add(0, 42, 8'hDF, 8'h92, 3'd5, 1'b0);
        add(0, 47, 8'hDF, 8'h92, 3'd5, 1'b0);
        add(0, 48, 8'hFF, 8'hFF, 3'd0, 1'b1);
        add(0, 49, 8'hFF, 8'hFF, 3'd0, 1'b0);
        add(0, 50, 8'hFE, 8'hC0, 3'd0, 1'b0);
        // scenario 1: bright 0 -> only pwm 0 lit
        add(1,  2, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(1,  3, 8'hFF, 8'hFF, 3'd0, 1'b0);
        add(1,  7, 8'hFF, 8'hFF, 3'd0, 1'b0);
        add(1, 10, 8'hFD, 8'hF9, 3'd1, 1'b0);
        add(1, 11, 8'hFF, 8'hFF, 3'd1, 1'b0);
        // scenario 2: bright 7 -> all six ON cycles lit
        add(2,  2, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(2,  7, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(2, 15, 8'hFD, 8'hF9, 3'd1, 1'b0);
        // scenario 3: bright 3 -> pwm 0..3 lit, 4..5 dark
        add(3,  2, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(3,  5, 8'hFE, 8'hC0, 3'd0, 1'b0);
        add(3,  6, 8'hFF, 8'hFF, 3'd0, 1'b0);
        add(3,  7, 8'hFF, 8'hFF, 3'd0, 1'b0);
        add(3, 10, 8'hFD, 8'hF9, 3'd1, 1'b0);
        add(3, 18, 8'hFF, 8'hFF, 3'd2, 1'b0);
        add(3, 26, 8'hF7, 8'hB0, 3'd3, 1'b0);
        add(3, 48, 8'hFF, 8'hFF, 3'd0, 1'b1);

        tick(); tick();
        check("reset_state", 8'hFF, 8'hFF, 3'd0, 1'b0);
        i_reset = 1'b0;
        tick();
        check("idle_after_reset", 8'hFF, 8'hFF, 3'd0, 1'b0);

        for (int s = 0; s < 4; s++) begin
            // scenario 3 also masks digit 3 (idx 2)
            if (s == 3) begin
                start_scan(en_cfg[s], bright_cfg[s]);
                for (int t = 16; t < 24; t++) begin
                    run_to(t);
                    check("masked_slot2", 8'hFF, 8'hFF, 3'd2, 1'b0);
                end
            end else begin
                start_scan(en_cfg[s], bright_cfg[s]);
            end
            foreach (vecs[k]) begin
                if (vecs[k].scen == s && vecs[k].t >= cyc) begin
                    run_to(vecs[k].t);
                    check($sformatf("vec_s%0d_t%0d", s, vecs[k].t),
                          vecs[k].seg, vecs[k].dig, vecs[k].idx, vecs[k].fs);
                end
            end
        end

        // snapshot coherence: new pattern mid-frame shows only after next frame start
        start_scan(6'h3F, 4'd15);
        tick();
        i_segout1 = 8'h80;
        run_to(2);
        check("snap_hold_cur_frame", 8'hFE, 8'hC0, 3'd0, 1'b0);
        i_segout1 = 8'hC0;
        run_to(27);
        i_segout1 = 8'h80;
        run_to(48);
        check("snap_frame_start", 8'hFF, 8'hFF, 3'd0, 1'b1);
        run_to(50);
        check("snap_new_value", 8'hFE, 8'h80, 3'd0, 1'b0);
        i_segout1 = 8'hC0;

        // enable drop during ON of idx 4, then restart from slot 0
        start_scan(6'h3F, 4'd15);
        run_to(35);
        check("pre_drop_on4", 8'hEF, 8'h99, 3'd4, 1'b0);
        i_enable = 1'b0;
        tick();
        check("enable_drop", 8'hFF, 8'hFF, 3'd0, 1'b0);
        tick();
        check("enable_parked", 8'hFF, 8'hFF, 3'd0, 1'b0);
        i_enable = 1'b1;
        tick();
        check("reenable_fs", 8'hFF, 8'hFF, 3'd0, 1'b1);
        tick();
        check("reenable_blank", 8'hFF, 8'hFF, 3'd0, 1'b0);
        tick();
        check("reenable_lit", 8'hFE, 8'hC0, 3'd0, 1'b0);

        // reset mid-ON with enable held
        start_scan(6'h3F, 4'd15);
        run_to(20);
        check("pre_reset_on2", 8'hFB, 8'hA4, 3'd2, 1'b0);
        i_reset = 1'b1;
        tick();
        check("mid_reset", 8'hFF, 8'hFF, 3'd0, 1'b0);
        i_reset = 1'b0;
        tick();
        check("post_reset_fs", 8'hFF, 8'hFF, 3'd0, 1'b1);
        tick();
        tick();
        check("post_reset_lit", 8'hFE, 8'hC0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
